byte_striping_tx_param: RTL and testbench
=========================================

# byte_striping_tx_param

Parametrised byte-striping distributor: accepts a serial stream of DW-bit words on a valid/ready handshake and stripes them round-robin across a runtime-selectable number of lanes (1..NLANES). Each complete group is presented in parallel on a single registered output with its own valid/ready handshake. A flush input closes a partial group by padding the unfilled lanes. It is the next generation of the fixed 4-lane, 8-bit striper and sits between the byte-stream source and the per-lane serialisers.

## Interface
- DW, 8, word width per lane
- NLANES, 4, physical lane count; power of 2, 1..8
- PAD, 8'hBC, DW-bit fill value for padded lanes and unused lanes
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low
- in_valid  input  1  input word valid
- in_data  input  DW  input word
- in_ready  output  1  block can accept a word this cycle
- flush  input  1  close current partial group (pad the rest)
- lanes_cfg  input  $clog2(NLANES)+1  requested active lane count
- out_valid  output  1  group valid
- out_ready  input  1  downstream accepts group
- out_data  output  NLANES*DW  lane k at bits [k*DW +: DW]
- out_lane_en  output  NLANES  lanes inside the active set of this group
- out_pad  output  NLANES  active lanes filled with PAD by flush
- cfg_err  output  1  one-cycle pulse: illegal lanes_cfg sampled

## Operation
- Reset: asynchronous, active-low, on clk. While reset is low: out_valid=0, out_data=0, out_lane_en=0, out_pad=0, cfg_err=0, idx=0, lanes_cur=NLANES, accumulator=0.
- Two parts: accumulator (NLANES*DW register, write index idx, current lane count lanes_cur) and one-entry output register (out_*).
- Accept rule: in_ready = !out_valid | out_ready. A word transfers when in_valid & in_ready.
- Accumulator states:
  - EMPTY (idx=0): on accept, sample lanes_cfg into lanes_cur. Legal values are 1..NLANES, power of 2. Any other value gives lanes_cur=NLANES and a cfg_err pulse the next cycle. The word goes to lane 0 and idx becomes 1. If lanes_cur=1, the group closes immediately.
  - FILLING (idx>0): on accept, the word goes to lane idx and idx increments. lanes_cfg is ignored.
- Group close, for either trigger: copy the accumulator to out_data, set out_valid=1, and set idx=0.
  - Trigger 1: accept at idx=lanes_cur-1.
  - Trigger 2: flush=1 & in_ready while idx>0, or while idx=0 together with an accepted word.
- Flush combined with an accepted word: the word is stored first, then the group closes. A flush that coincides with the group-completing word adds no padding.
- Flush with idx=0 and no accepted word: ignored. Empty groups are never emitted.
- Flush with in_ready=0: ignored. Upstream must hold it.
- Output register contents for a closed group:
  - out_lane_en: bits 0..lanes_cur-1 set.
  - Active lanes at or above the final fill position carry PAD, with the out_pad bit set.
  - Lanes at or above lanes_cur carry PAD, with out_lane_en=0 and out_pad=0.
- Output handshake:
  - out_valid & out_ready clears out_valid, unless a new group closes on the same edge; then out_* is reloaded and out_valid stays 1.
  - out_* is stable while out_valid & !out_ready.
- lanes_cfg changes mid-group have no effect until the next EMPTY accept.

## Timing
- Latency: the last word of a group is accepted at edge N; out_valid=1 and the data are visible after edge N.
- Throughput: with out_ready held at 1, one word per cycle and one group every lanes_cur cycles, with no bubbles.
- Back-pressure: in_ready is combinational from out_valid/out_ready. in_ready=0 only while out_valid & !out_ready.
- cfg_err: asserted the cycle after the illegal sample, for one cycle.
- Reset asserted mid-group: the partial group and any pending output are discarded with no emission. After reset release the block starts EMPTY with lanes_cur=NLANES.

## Test plan
- Defaults, lanes_cfg=4, out_ready=1, words 01..08 on consecutive cycles -> out_data=04030201 after word 4 and 08070605 after word 8; out_lane_en=4'hF; out_pad=0; in_ready always 1.
- lanes_cfg=2, words A1 A2 A3 A4 -> groups {BC,BC,A2,A1} then {BC,BC,A4,A3}; out_lane_en=4'h3; out_pad=0.
- lanes_cfg=4, words 11 22, then flush alone -> out_data=BCBC2211, out_lane_en=F, out_pad=4'hC. A following flush with no data produces no output.
- out_ready=0 with one group pending, in_valid high -> in_ready=0, no word lost, out_data stable. Raising out_ready drains the group and the next group follows without a gap.
- lanes_cfg=3 at group start -> cfg_err pulse, group is 4 lanes. Changing lanes_cfg from 4 to 1 mid-group -> current group stays 4 lanes and the next group is 1 lane.
- Reset pulsed low after 2 of 4 words -> out_valid stays 0. The next 4 words form a clean group on lanes 0..3.

Source files
------------

// File: rtl/byte_striping_tx_param.sv
// byte_striping_tx_param: stripes a serial word stream round-robin across 1..NLANES lanes
// and presents each closed group on a registered valid/ready output.
module byte_striping_tx_param #(
  parameter int DW = 8,
  parameter int NLANES = 4,
  parameter logic [DW-1:0] PAD = 8'hBC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_data,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic [$clog2(NLANES):0]  lanes_cfg,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NLANES*DW-1:0]     out_data,
  output logic [NLANES-1:0]        out_lane_en,
  output logic [NLANES-1:0]        out_pad,
  output logic                     cfg_err
);
  localparam int LW = $clog2(NLANES) + 1;
  logic [NLANES*DW-1:0] acc, acc_nx, data_nx;
  logic [LW-1:0] idx, lanes_cur, lanes_eff, fill;
  logic [NLANES-1:0] en_nx, pad_nx;
  logic take, empty, legal, close;
  assign in_ready = !out_valid || out_ready;
  assign take = in_valid && in_ready;
  assign empty = idx == '0;
  assign legal = lanes_cfg != '0 && lanes_cfg <= LW'(NLANES) && (lanes_cfg & (lanes_cfg - LW'(1))) == '0;
  // lane count is only sampled on the first word of a group
  assign lanes_eff = empty ? (legal ? lanes_cfg : LW'(NLANES)) : lanes_cur;
  assign fill = take ? idx + LW'(1) : idx;
  assign close = (take && fill == lanes_eff) || (flush && in_ready && fill != '0);
  always_comb begin
    acc_nx = acc;
    data_nx = '0;
    en_nx = '0;
    pad_nx = '0;
    if (take) acc_nx[int'(idx)*DW +: DW] = in_data;
    for (int k = 0; k < NLANES; k++) begin
      data_nx[k*DW +: DW] = LW'(k) < fill ? acc_nx[k*DW +: DW] : PAD;
      en_nx[k] = LW'(k) < lanes_eff;
      pad_nx[k] = LW'(k) >= fill && LW'(k) < lanes_eff;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      idx <= '0;
      lanes_cur <= LW'(NLANES);
      out_valid <= 1'b0;
      out_data <= '0;
      out_lane_en <= '0;
      out_pad <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= take && empty && !legal;
      if (take && empty) lanes_cur <= lanes_eff;
      if (take) acc <= acc_nx;
      idx <= close ? '0 : fill;
      if (close) begin
        out_valid <= 1'b1;
        out_data <= data_nx;
        out_lane_en <= en_nx;
        out_pad <= pad_nx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_byte_striping_tx_param.sv
// tb_byte_striping_tx_param: directed and random stimulus checked against a queue-based group model.
module tb_byte_striping_tx_param;
  localparam int DW = 8;
  localparam int N = 4;
  localparam int LW = $clog2(N) + 1;
  localparam logic [DW-1:0] PAD = 8'hBC;
  logic clk = 0, reset = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic [DW-1:0] in_data = '0;
  logic [LW-1:0] lanes_cfg = '0;
  logic in_ready, out_valid, cfg_err;
  logic [N*DW-1:0] out_data;
  logic [N-1:0] out_lane_en, out_pad;
  int vec = 0, bad = 0;
  logic ev = 0, eerr = 0;
  logic [N*DW-1:0] ed = '0;
  logic [N-1:0] een = '0, epad = '0;
  int mlanes = N;
  logic [DW-1:0] grp[$];

  byte_striping_tx_param #(.DW(DW), .NLANES(N), .PAD(PAD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .lanes_cfg(lanes_cfg), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lane_en(out_lane_en), .out_pad(out_pad), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // one clock: drive at negedge, check in_ready, advance model, check outputs after the edge
  task automatic step(input logic v, input logic [DW-1:0] d, input logic f, input int cfg, input logic r);
    logic rdy, acc, cl;
    int n;
    in_valid = v; in_data = d; flush = f; lanes_cfg = LW'(cfg); out_ready = r;
    #1;
    rdy = !ev || r;
    check("in_ready", in_ready, rdy);
    acc = v && rdy;
    eerr = 0;
    if (acc) begin
      if (grp.size() == 0) begin
        if (cfg >= 1 && cfg <= N && $countones(cfg) == 1) mlanes = cfg;
        else begin mlanes = N; eerr = 1; end
      end
      grp.push_back(d);
    end
    n = grp.size();
    cl = (acc && n == mlanes) || (f && rdy && n > 0);
    if (cl) begin
      ev = 1;
      for (int k = 0; k < N; k++) begin
        ed[k*DW +: DW] = k < n ? grp[k] : PAD;
        een[k] = k < mlanes;
        epad[k] = k >= n && k < mlanes;
      end
      grp.delete();
    end else if (ev && r) ev = 0;
    @(posedge clk); #1;
    check("out_valid", out_valid, ev);
    if (ev) begin
      check("out_data", out_data, ed);
      check("out_lane_en", out_lane_en, een);
      check("out_pad", out_pad, epad);
    end
    check("cfg_err", cfg_err, eerr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 0; in_valid = 0; flush = 0;
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, '0);
    check("rst_en", out_lane_en, '0);
    check("rst_pad", out_pad, '0);
    check("rst_err", cfg_err, 1'b0);
    ev = 0; eerr = 0; mlanes = N; grp.delete();
    @(negedge clk); @(negedge clk);
    reset = 1;
  endtask

  initial begin
    do_reset();
    for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 4, 1);
    step(0, 0, 0, 4, 1);
    for (int i = 1; i <= 4; i++) step(1, DW'(8'hA0 + i), 0, 2, 1);
    step(0, 0, 0, 4, 1);
    step(1, 8'h11, 0, 4, 1);
    step(1, 8'h22, 0, 4, 1);
    step(0, 0, 1, 4, 1);
    step(0, 0, 1, 4, 1);
    step(0, 0, 0, 4, 1);
    for (int i = 1; i <= 4; i++) step(1, DW'(i), 0, 4, 0);
    for (int i = 0; i < 3; i++) step(1, 8'h05, 0, 4, 0);
    for (int i = 5; i <= 8; i++) step(1, DW'(i), 0, 4, 1);
    step(0, 0, 0, 4, 1);
    step(1, 8'h31, 0, 3, 1);
    step(1, 8'h32, 0, 1, 1);
    step(1, 8'h33, 0, 1, 1);
    step(1, 8'h34, 0, 1, 1);
    step(1, 8'h35, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(1, 8'h41, 0, 4, 1);
    step(1, 8'h42, 0, 4, 1);
    @(negedge clk);
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, DW'(8'h50 + i), 0, 4, 1);
    step(0, 0, 0, 4, 1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 7), $urandom_range(0, 3) != 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
